// File: rtl/universal_register.sv
// WIDTH-bit register with hold/load/shift/rotate/increment/decrement modes, complementary outputs,
// a registered carry/shift-out flag and a zero flag. Asynchronous active-low reset presets Q.
module universal_register #(
  parameter int unsigned          WIDTH       = 4,
  parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             input_clock1_clk_1,
  input  logic             input_input_switch2__reset_2,
  input  logic             input_input_switch3_en_3,
  input  logic [2:0]       input_input_switch4_mode_4,
  input  logic [WIDTH-1:0] input_input_switch5_d_5,
  input  logic             input_input_switch6_sin_r_6,
  input  logic             input_input_switch7_sin_l_7,
  output logic [WIDTH-1:0] output_led1_q_8,
  output logic [WIDTH-1:0] output_led2_qn_9,
  output logic             output_led3_carry_10,
  output logic             output_led4_zero_11,
  output logic             output_led5_sout_r_12,
  output logic             output_led6_sout_l_13
);

  typedef enum logic [2:0] {
    ModeHold = 3'b000,
    ModeLoad = 3'b001,
    ModeShr  = 3'b010,
    ModeShl  = 3'b011,
    ModeRor  = 3'b100,
    ModeRol  = 3'b101,
    ModeInc  = 3'b110,
    ModeDec  = 3'b111
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  assign mode = mode_e'(input_input_switch4_mode_4);

  // One bit wider than Q so the top bit is the carry (inc) or borrow (dec).
  assign sum  = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
  assign diff = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
    if (input_input_switch3_en_3) begin
      unique case (mode)
        ModeHold: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
        ModeLoad: begin
          q_d     = input_input_switch5_d_5;
          carry_d = 1'b0;
        end
        ModeShr: begin
          q_d     = {input_input_switch6_sin_r_6, q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        ModeShl: begin
          q_d     = {q_q[WIDTH-2:0], input_input_switch7_sin_l_7};
          carry_d = q_q[WIDTH-1];
        end
        ModeRor: begin
          q_d     = {q_q[0], q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        ModeRol: begin
          q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          carry_d = q_q[WIDTH-1];
        end
        ModeInc: begin
          q_d     = sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
        end
        ModeDec: begin
          q_d     = diff[WIDTH-1:0];
          carry_d = diff[WIDTH];
        end
        default: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
      endcase
    end
  end

  always_ff @(posedge input_clock1_clk_1 or negedge input_input_switch2__reset_2) begin
    if (!input_input_switch2__reset_2) begin
      q_q     <= RESET_VALUE;
      carry_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
    end
  end

  assign output_led1_q_8       = q_q;
  assign output_led2_qn_9      = ~q_q;
  assign output_led3_carry_10  = carry_q;
  assign output_led4_zero_11   = (q_q == '0);
  assign output_led5_sout_r_12 = q_q[0];
  assign output_led6_sout_l_13 = q_q[WIDTH-1];

endmodule

// File: tb/tb_universal_register.sv
// Directed self-checking bench for universal_register: a 4-bit preset instance and an
// 8-bit zero-reset instance sharing one clock.
module tb_universal_register;

  logic       clk;
  int         checks;
  int         errors;

  // 4-bit instance, RESET_VALUE = 4'hF
  logic       rst_n, en, sin_r, sin_l;
  logic [2:0] mode;
  logic [3:0] d, q, qn;
  logic       carry, zero, sout_r, sout_l;

  // 8-bit instance, RESET_VALUE = 8'h00
  logic       rst8_n, en8;
  logic [2:0] mode8;
  logic [7:0] d8, q8, qn8;
  logic       carry8, zero8, sout_r8, sout_l8;

  universal_register #(.WIDTH(4), .RESET_VALUE(4'hF)) dut4 (
    .input_clock1_clk_1          (clk),
    .input_input_switch2__reset_2(rst_n),
    .input_input_switch3_en_3    (en),
    .input_input_switch4_mode_4  (mode),
    .input_input_switch5_d_5     (d),
    .input_input_switch6_sin_r_6 (sin_r),
    .input_input_switch7_sin_l_7 (sin_l),
    .output_led1_q_8             (q),
    .output_led2_qn_9            (qn),
    .output_led3_carry_10        (carry),
    .output_led4_zero_11         (zero),
    .output_led5_sout_r_12       (sout_r),
    .output_led6_sout_l_13       (sout_l)
  );

  universal_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut8 (
    .input_clock1_clk_1          (clk),
    .input_input_switch2__reset_2(rst8_n),
    .input_input_switch3_en_3    (en8),
    .input_input_switch4_mode_4  (mode8),
    .input_input_switch5_d_5     (d8),
    .input_input_switch6_sin_r_6 (1'b0),
    .input_input_switch7_sin_l_7 (1'b0),
    .output_led1_q_8             (q8),
    .output_led2_qn_9            (qn8),
    .output_led3_carry_10        (carry8),
    .output_led4_zero_11         (zero8),
    .output_led5_sout_r_12       (sout_r8),
    .output_led6_sout_l_13       (sout_l8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive_slot();
    @(negedge clk);
    #1;
  endtask

  task automatic edge_and_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en = 1'b1; mode = 3'b110; d = 4'h0; sin_r = 1'b0; sin_l = 1'b0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL reset_q: got %h expected %h", q, 4'hF); end
    checks++; if (qn !== 4'h0) begin errors++; $display("FAIL reset_qn: got %h expected %h", qn, 4'h0); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", zero); end
    // Edges during reset must not count.
    edge_and_sample();
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL reset_edge_q: got %h expected %h", q, 4'hF); end
    drive_slot();
    rst_n = 1'b1; mode = 3'b000; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_and_sample();
      checks++; if (q !== 4'hF) begin errors++; $display("FAIL reset_hold_q[%0d]: got %h expected %h", i, q, 4'hF); end
    end
  endtask

  task automatic test_load_enable();
    drive_slot();
    mode = 3'b001; d = 4'hA; en = 1'b1;
    edge_and_sample();
    checks++; if (q !== 4'hA) begin errors++; $display("FAIL load_q: got %h expected %h", q, 4'hA); end
    checks++; if (qn !== 4'h5) begin errors++; $display("FAIL load_qn: got %h expected %h", qn, 4'h5); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL load_carry: got %b expected 0", carry); end
    drive_slot();
    d = 4'h3; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      edge_and_sample();
      checks++; if (q !== 4'hA) begin errors++; $display("FAIL en_hold_q[%0d]: got %h expected %h", i, q, 4'hA); end
    end
  endtask

  task automatic test_shifts();
    drive_slot();
    en = 1'b1; mode = 3'b010; sin_r = 1'b1;
    edge_and_sample();
    checks++; if (q !== 4'hD) begin errors++; $display("FAIL shr_q: got %h expected %h", q, 4'hD); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL shr_carry: got %b expected 0", carry); end
    drive_slot();
    mode = 3'b011; sin_l = 1'b0;
    edge_and_sample();
    checks++; if (q !== 4'hA) begin errors++; $display("FAIL shl_q: got %h expected %h", q, 4'hA); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL shl_carry: got %b expected 1", carry); end
    drive_slot();
    mode = 3'b100;
    edge_and_sample();
    checks++; if (q !== 4'h5) begin errors++; $display("FAIL ror1_q: got %h expected %h", q, 4'h5); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL ror1_carry: got %b expected 0", carry); end
    edge_and_sample();
    checks++; if (q !== 4'hA) begin errors++; $display("FAIL ror2_q: got %h expected %h", q, 4'hA); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL ror2_carry: got %b expected 1", carry); end
    drive_slot();
    mode = 3'b101;
    edge_and_sample();
    checks++; if (q !== 4'h5) begin errors++; $display("FAIL rol_q: got %h expected %h", q, 4'h5); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL rol_carry: got %b expected 1", carry); end
    checks++; if (sout_r !== 1'b1) begin errors++; $display("FAIL sout_r: got %b expected 1", sout_r); end
    checks++; if (sout_l !== 1'b0) begin errors++; $display("FAIL sout_l: got %b expected 0", sout_l); end
  endtask

  task automatic test_increment();
    drive_slot();
    mode = 3'b001; d = 4'hE; en = 1'b1;
    edge_and_sample();
    drive_slot();
    mode = 3'b110;
    edge_and_sample();
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL inc1_q: got %h expected %h", q, 4'hF); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL inc1_carry: got %b expected 0", carry); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL inc1_zero: got %b expected 0", zero); end
    edge_and_sample();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL inc2_q: got %h expected %h", q, 4'h0); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL inc2_carry: got %b expected 1", carry); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL inc2_zero: got %b expected 1", zero); end
    edge_and_sample();
    checks++; if (q !== 4'h1) begin errors++; $display("FAIL inc3_q: got %h expected %h", q, 4'h1); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL inc3_carry: got %b expected 0", carry); end
  endtask

  task automatic test_decrement();
    drive_slot();
    mode = 3'b001; d = 4'h1; en = 1'b1;
    edge_and_sample();
    drive_slot();
    mode = 3'b111;
    edge_and_sample();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL dec1_q: got %h expected %h", q, 4'h0); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL dec1_zero: got %b expected 1", zero); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL dec1_carry: got %b expected 0", carry); end
    edge_and_sample();
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL dec2_q: got %h expected %h", q, 4'hF); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL dec2_carry: got %b expected 1", carry); end
    // Hold mode keeps both Q and the carry.
    drive_slot();
    mode = 3'b000;
    edge_and_sample();
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL hold_q: got %h expected %h", q, 4'hF); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL hold_carry: got %b expected 1", carry); end
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] exp;
    drive_slot();
    mode = 3'b001; d = 4'h0; en = 1'b1;
    edge_and_sample();
    drive_slot();
    mode = 3'b110;
    exp = 4'h0;
    for (int i = 0; i < 5; i++) begin
      edge_and_sample();
      exp = exp + 4'h1;
      checks++; if (q !== exp) begin errors++; $display("FAIL count_q[%0d]: got %h expected %h", i, q, exp); end
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL midreset_q: got %h expected %h", q, 4'hF); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL midreset_carry: got %b expected 0", carry); end
    @(negedge clk);
    rst_n = 1'b1;
    edge_and_sample();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL resume_q: got %h expected %h", q, 4'h0); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL resume_carry: got %b expected 1", carry); end
  endtask

  task automatic test_width8();
    drive_slot();
    rst8_n = 1'b1; en8 = 1'b1; mode8 = 3'b110;
    for (int i = 0; i < 3; i++) edge_and_sample();
    checks++; if (q8 !== 8'h03) begin errors++; $display("FAIL w8_count_q: got %h expected %h", q8, 8'h03); end
    #1;
    rst8_n = 1'b0;
    #1;
    checks++; if (q8 !== 8'h00) begin errors++; $display("FAIL w8_reset_q: got %h expected %h", q8, 8'h00); end
    checks++; if (zero8 !== 1'b1) begin errors++; $display("FAIL w8_reset_zero: got %b expected 1", zero8); end
    checks++; if (qn8 !== 8'hFF) begin errors++; $display("FAIL w8_reset_qn: got %h expected %h", qn8, 8'hFF); end
    @(negedge clk);
    rst8_n = 1'b1;
    edge_and_sample();
    checks++; if (q8 !== 8'h01) begin errors++; $display("FAIL w8_resume_q: got %h expected %h", q8, 8'h01); end
    checks++; if (carry8 !== 1'b0) begin errors++; $display("FAIL w8_resume_carry: got %b expected 0", carry8); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst8_n = 1'b0; en8 = 1'b0; mode8 = 3'b000; d8 = 8'h00;
    test_reset();
    test_load_enable();
    test_shifts();
    test_increment();
    test_decrement();
    test_reset_mid_count();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
